// File: rtl/spike_aer_tx.sv
// Drains spike events from the FIFO read port onto the off-core AER bus using a
// four-phase req/ack handshake; the asynchronous acknowledge is synchronized locally.
module spike_aer_tx #(
    parameter int M           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN_i,
    input  logic             FIFO_empty_i,
    output logic             FIFO_r_en_o,
    input  logic [M-1:0]     FIFO_r_data_i,
    output logic [M-1:0]     AER_ADDR_o,
    output logic             AER_REQ_o,
    input  logic             AER_ACK_i,
    output logic             BUSY_o,
    output logic [CNT_W-1:0] EVT_CNT_o,
    output logic             PROTO_ERR_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_SETUP,
        S_REQ,
        S_RELEASE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [M-1:0]           r_addr;
    logic                   r_req;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_err;

    logic                   w_ack_s;
    logic                   w_start;
    logic                   w_release_done;
    logic                   w_early_ack;

    assign w_ack_s        = r_ack_sync[SYNC_STAGES-1];
    assign w_start        = EN_i & ~FIFO_empty_i;
    assign w_release_done = (r_state == S_RELEASE) && !w_ack_s;
    // An acknowledge seen before the request is raised violates the protocol.
    assign w_early_ack    = w_ack_s && (r_state inside {S_IDLE, S_POP, S_LOAD, S_SETUP});

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], AER_ACK_i};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start && !w_ack_s) begin
                    w_state_nxt = S_POP;
                end
            end
            S_POP:   w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SETUP;
            S_SETUP: w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_ack_s) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!w_ack_s) begin
                    w_state_nxt = w_start ? S_POP : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr <= '0;
            r_req  <= 1'b0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_addr <= FIFO_r_data_i;
            end
            if (r_state == S_SETUP) begin
                r_req <= 1'b1;
            end else if ((r_state == S_REQ) && w_ack_s) begin
                r_req <= 1'b0;
            end
            if (w_release_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_early_ack) begin
                r_err <= 1'b1;
            end
        end
    end

    assign FIFO_r_en_o = (r_state == S_POP);
    assign BUSY_o      = (r_state != S_IDLE);
    assign AER_ADDR_o  = r_addr;
    assign AER_REQ_o   = r_req;
    assign EVT_CNT_o   = r_cnt;
    assign PROTO_ERR_o = r_err;

endmodule

// File: tb/tb_spike_aer_tx.sv
// Bench for spike_aer_tx: FIFO model, delayed AER responder, stream/count reference model.
module tb_spike_aer_tx;
    localparam int M     = 8;
    localparam int SYNC  = 2;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EN  = 1'b0;
    logic             FIFO_empty;
    logic             FIFO_r_en;
    logic [M-1:0]     fifo_rdata = '0;
    logic [M-1:0]     addr;
    logic             req;
    logic             ACK;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             resp_ack = 1'b0;
    logic             man_ack  = 1'b0;

    int total = 0;
    int bad   = 0;

    assign ACK = resp_ack | man_ack;

    spike_aer_tx #(.M(M), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .EN_i(EN), .FIFO_empty_i(FIFO_empty),
        .FIFO_r_en_o(FIFO_r_en), .FIFO_r_data_i(fifo_rdata),
        .AER_ADDR_o(addr), .AER_REQ_o(req), .AER_ACK_i(ACK),
        .BUSY_o(busy), .EVT_CNT_o(cnt), .PROTO_ERR_o(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model with registered read data
    logic [M-1:0] mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [M-1:0] exp_q[$];
    logic [M-1:0] rx_q[$];
    int model_cnt = 0;

    assign FIFO_empty = (wr_ptr == rd_ptr);

    always @(posedge CLK) begin
        if (FIFO_r_en) begin
            fifo_rdata <= mem[rd_ptr % 256];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [M-1:0] v);
        mem[wr_ptr % 256] = v;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(v);
    endtask

    // Responder: raises ack resp_dly cycles after req, drops it when req falls
    bit resp_on   = 1'b1;
    int resp_dly  = 0;
    int resp_wait = 0;

    always @(negedge CLK) begin
        if (!resp_on) begin
            resp_ack  <= 1'b0;
            resp_wait <= 0;
        end else if (!resp_ack && req) begin
            if (resp_wait >= resp_dly) begin
                resp_ack  <= 1'b1;
                resp_wait <= 0;
                rx_q.push_back(addr);
            end else begin
                resp_wait <= resp_wait + 1;
            end
        end else if (resp_ack && !req) begin
            resp_ack <= 1'b0;
        end
    end

    // Continuous protocol monitor
    bit           mon_on = 1'b0;
    logic         p_ren  = 1'b0;
    logic         pp_ren = 1'b0;
    logic         p_req  = 1'b0;
    logic [M-1:0] p_addr = '0;

    always @(negedge CLK) begin
        if (mon_on && !RST) begin
            if (FIFO_r_en) begin
                check("rd_while_empty", 32'(FIFO_empty), 0);
                check("rd_pulse_width", 32'(p_ren), 0);
            end
            if (req && !p_req) check("addr_before_req", 32'(addr), 32'(p_addr));
            if (addr !== p_addr) check("addr_change_after_load", 32'(pp_ren), 1);
        end
        p_ren  <= FIFO_r_en;
        pp_ren <= p_ren;
        p_req  <= req;
        p_addr <= addr;
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        repeat (n) tick();
        RST = 1'b0;
        model_cnt = 0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic wait_req();
        int k;
        for (k = 0; k < 200; k++) begin
            if (req) break;
            tick();
        end
        if (k == 200) timeout_fail("wait_req");
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            if (!busy) break;
            tick();
        end
        if (k == 200) timeout_fail("wait_idle");
    endtask

    task automatic wait_drain(input int n, output int gaps);
        int k;
        gaps = 0;
        for (k = 0; k < 3000; k++) begin
            tick();
            if (rx_q.size() == n && !busy && FIFO_empty) break;
            if (!busy && rx_q.size() > 0 && rx_q.size() < n) gaps++;
        end
        if (k == 3000) timeout_fail("drain");
    endtask

    task automatic cmp_stream(input string name);
        check({name, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check({name, "_addr"}, 32'(rx_q[i]), 32'(exp_q[i]));
        model_cnt = model_cnt + exp_q.size();
        rx_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        int               nev;
        int               dly;
        logic [M-1:0]     base;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   gaps;
        int   n;
        vecs[0] = '{1,  5, 8'hA5, 4'd1};
        vecs[1] = '{16, 0, 8'h01, 4'd0};
        vecs[2] = '{3,  2, 8'h40, 4'd3};
        vecs[3] = '{17, 0, 8'h80, 4'd1};
        vecs[4] = '{2,  7, 8'hFE, 4'd2};

        // Reset with acknowledge held high
        man_ack = 1'b1;
        RST = 1'b1;
        repeat (3) tick();
        check("rst_req", 32'(req), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_ren", 32'(FIFO_r_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_err", 32'(err), 0);
        RST = 1'b0;
        tick();
        tick();
        check("sync_err_early", 32'(err), 0);
        tick();
        check("sync_err_set", 32'(err), 1);
        check("sync_no_req", 32'(req), 0);
        man_ack = 1'b0;
        do_reset(2);
        check("err_cleared", 32'(err), 0);
        mon_on = 1'b1;

        // Single event: exact start, ack-rise and ack-fall latencies
        EN = 1'b1;
        resp_dly = 5;
        push(8'hA5);
        tick();
        check("lat_ren", 32'(FIFO_r_en), 1);
        tick();
        check("lat_ren_off", 32'(FIFO_r_en), 0);
        tick();
        check("lat_addr", 32'(addr), 32'hA5);
        check("lat_setup_req", 32'(req), 0);
        tick();
        check("lat_req", 32'(req), 1);
        for (int k = 0; k < 50; k++) begin
            if (ACK) break;
            tick();
        end
        tick();
        check("ackr_req1", 32'(req), 1);
        tick();
        check("ackr_req2", 32'(req), 1);
        tick();
        check("ackr_req3", 32'(req), 0);
        tick();
        tick();
        check("ackf_cnt_hold", 32'(cnt), 0);
        check("ackf_busy_hold", 32'(busy), 1);
        tick();
        check("ackf_cnt", 32'(cnt), 1);
        check("ackf_busy", 32'(busy), 0);
        cmp_stream("single");

        // Table-driven bursts
        for (int v = 0; v < 5; v++) begin
            do_reset(2);
            resp_dly = vecs[v].dly;
            for (int i = 0; i < vecs[v].nev; i++) push(vecs[v].base + M'(i));
            wait_drain(vecs[v].nev, gaps);
            check("vec_gaps", 32'(gaps), 0);
            check("vec_cnt", 32'(cnt), 32'(vecs[v].exp_cnt));
            check("vec_err", 32'(err), 0);
            check("vec_fifo_empty", 32'(FIFO_empty), 1);
            cmp_stream("vec");
        end

        // EN deasserted during REQ of the first of three events
        do_reset(2);
        resp_dly = 3;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        wait_req();
        EN = 1'b0;
        wait_idle();
        repeat (5) tick();
        check("en_busy", 32'(busy), 0);
        check("en_left", 32'(wr_ptr - rd_ptr), 2);
        check("en_cnt", 32'(cnt), 1);
        EN = 1'b1;
        wait_drain(3, gaps);
        check("en_cnt_all", 32'(cnt), 3);
        cmp_stream("en");

        // Reset while the request is high: event lost, no extra read
        do_reset(2);
        resp_on = 1'b0;
        push(8'h77);
        wait_req();
        tick();
        tick();
        RST = 1'b1;
        tick();
        check("mid_req", 32'(req), 0);
        check("mid_cnt", 32'(cnt), 0);
        check("mid_busy", 32'(busy), 0);
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mid_no_ren", 32'(FIFO_r_en), 0);
        end
        check("mid_fifo_empty", 32'(FIFO_empty), 1);
        exp_q.delete();
        rx_q.delete();
        resp_on = 1'b1;

        // Acknowledge in IDLE: sticky error, start blocked while ack_s is high
        do_reset(2);
        resp_dly = 1;
        man_ack = 1'b1;
        repeat (4) tick();
        man_ack = 1'b0;
        repeat (4) tick();
        check("perr_set", 32'(err), 1);
        check("perr_no_req", 32'(req), 0);
        check("perr_idle", 32'(busy), 0);
        man_ack = 1'b1;
        repeat (3) tick();
        push(8'h5A);
        repeat (4) tick();
        check("perr_blocked", 32'(busy), 0);
        check("perr_queued", 32'(wr_ptr - rd_ptr), 1);
        man_ack = 1'b0;
        wait_drain(1, gaps);
        check("perr_sticky", 32'(err), 1);
        check("perr_cnt", 32'(cnt), 1);
        cmp_stream("perr");
        do_reset(2);
        check("perr_clear", 32'(err), 0);

        // Randomized traffic against the stream/count model
        for (int r = 0; r < 30; r++) begin
            resp_dly = $urandom_range(0, 4);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                push(M'($urandom));
                EN = ($urandom_range(0, 3) != 0);
                repeat ($urandom_range(0, 3)) tick();
            end
            EN = 1'b1;
            wait_drain(n, gaps);
            cmp_stream("rand");
            check("rand_cnt", 32'(cnt), 32'(model_cnt % (1 << CNT_W)));
            check("rand_err", 32'(err), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spike_aer_tx.md
# spike_aer_tx

Drain side of the tinyODIN spike FIFO. The block pops spike events from the FIFO read port and emits each one on an off-core AER output bus using a four-phase bundled-data req/ack handshake. The acknowledge input is asynchronous and is synchronized inside the block. The block sits between the FIFO read port and the chip-level AER output pads.

## Interface
Parameters:
- M, 8: spike event / AER address width; must equal the FIFO data width.
- SYNC_STAGES, 2: flops in the AER_ACK_i synchronizer; minimum 2.
- CNT_W, 16: width of the sent-event counter.

Ports:
- CLK  in  1  single clock for the whole block.
- RST  in  1  reset; synchronous, active-high (polarity and synchronicity fixed).
- EN_i  in  1  enables starting new events; a transfer already in flight always completes.
- FIFO_empty_i  in  1  FIFO empty flag.
- FIFO_r_en_o  out  1  FIFO read strobe; the FIFO updates FIFO_r_data_i at the end of the strobe cycle.
- FIFO_r_data_i  in  M  FIFO registered read data, valid from the cycle after the strobe.
- AER_ADDR_o  out  M  AER event address, registered.
- AER_REQ_o  out  1  AER request, registered.
- AER_ACK_i  in  1  AER acknowledge, asynchronous.
- BUSY_o  out  1  high when the FSM is not in IDLE.
- EVT_CNT_o  out  CNT_W  number of completed handshakes; wraps modulo 2^CNT_W.
- PROTO_ERR_o  out  1  sticky flag for an acknowledge protocol violation.

## Operation
- ack_s is AER_ACK_i after SYNC_STAGES flops. Only ack_s is used internally.
- FSM states are IDLE, POP, LOAD, SETUP, REQ and RELEASE.
- IDLE: go to POP if EN_i & ~FIFO_empty_i & ~ack_s; otherwise stay.
- POP: FIFO_r_en_o=1, decoded from the state register only. Always go to LOAD.
- LOAD: AER_ADDR_o <= FIFO_r_data_i at the end of the cycle. Go to SETUP.
- SETUP: address is stable and AER_REQ_o=0 for this one cycle. Set AER_REQ_o <= 1 at the end of the cycle. Go to REQ.
- REQ: hold AER_REQ_o=1 and AER_ADDR_o. When ack_s=1, clear AER_REQ_o <= 0 and go to RELEASE.
- RELEASE: hold AER_ADDR_o and wait for ack_s=0. On that edge:
  - increment EVT_CNT_o;
  - go to POP if EN_i & ~FIFO_empty_i, else go to IDLE.
- FIFO_r_en_o is asserted only in POP, so the block never strobes the FIFO while it is empty.
- AER_ADDR_o changes only at the end of LOAD. It is stable from SETUP through the end of RELEASE.
- PROTO_ERR_o is set when ack_s=1 while in IDLE, POP, LOAD or SETUP. It is cleared only by RST.
  - If ack_s=1 in IDLE, no new event is started.
  - In POP/LOAD/SETUP the FSM still proceeds.
- EN_i is sampled only in IDLE and RELEASE. Deasserting it mid-transfer does not abort the transfer.

## Timing
- Reset values (RST high at a rising edge) take effect the next cycle:
  - state=IDLE;
  - AER_REQ_o=0, AER_ADDR_o=0, FIFO_r_en_o=0;
  - BUSY_o=0, EVT_CNT_o=0, PROTO_ERR_o=0;
  - all synchronizer flops=0.
- Reset mid-handshake: AER_REQ_o drops in the cycle after RST is sampled. A popped but unacknowledged event is lost and is not counted.
- Start latency: FIFO_empty_i is seen low in IDLE in cycle t.
  - FIFO_r_en_o is high in t+1.
  - AER_ADDR_o is valid from t+3.
  - AER_REQ_o rises in t+4.
- Acknowledge-rise latency: AER_ACK_i rises before edge e. ack_s is high after SYNC_STAGES edges, and AER_REQ_o is low after the following edge. That is SYNC_STAGES+1 edges after e.
- Acknowledge-fall latency: same SYNC_STAGES+1 edges from AER_ACK_i falling to the RELEASE exit.
- Back-to-back events go RELEASE to POP with no IDLE cycle. Minimum 4 cycles from the RELEASE exit to the next request rise.
- EVT_CNT_o updates in the cycle after the RELEASE exit. Wrap-around from 2^CNT_W-1 goes to 0 with no flag.

## Test plan
- Reset values: hold RST for 3 cycles with AER_ACK_i=1 -> all outputs 0 and PROTO_ERR_o=0. The synchronizer is held at 0 during reset; after release, ack_s reaches 1 and sets PROTO_ERR_o in IDLE.
- Single event: FIFO holds 0xA5, responder acknowledges after 5 cycles -> FIFO_r_en_o is a single-cycle pulse, AER_ADDR_o=0xA5 one cycle before AER_REQ_o rises, full 4-phase handshake, EVT_CNT_o=1, BUSY_o returns to 0.
- Burst: push 0x01..0x10 (16 events), immediate responder -> 16 handshakes in order, no IDLE between events, EVT_CNT_o=16, FIFO empty at the end.
- EN_i gating: deassert EN_i during REQ of event 1 with 3 events queued -> event 1 completes, then IDLE with 2 events still queued. Reassert EN_i -> the remaining 2 events are sent.
- Reset mid-handshake: pulse RST while AER_REQ_o=1 -> AER_REQ_o=0 next cycle, EVT_CNT_o=0, and no spurious FIFO_r_en_o.
- Protocol error and wrap: pulse AER_ACK_i high in IDLE -> PROTO_ERR_o=1 and no request issued. With CNT_W=4, send 17 events -> EVT_CNT_o=1.
